// File: rtl/mux9_rr_collector.sv
// Round-robin 9-to-1 collector: arbitrates nine request lanes onto one registered
// valid/ready stream, tagging each word with its lane index. Define MUX9_STATS_EN to add xfer_count.
module mux9_rr_collector #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8:0]     req,
  input  logic [9*W-1:0] din,
  output logic [8:0]     grant,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [3:0]     out_sel
`ifdef MUX9_STATS_EN
  ,
  output logic [15:0]    xfer_count
`endif
);

  localparam int unsigned LANES = 9;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         r_state;
  logic [3:0]     r_ptr;
  logic [W-1:0]   r_data;
  logic [3:0]     r_sel;
  logic           w_load;
  logic           w_found;
  logic [3:0]     w_idx;

  assign w_load = (r_state == EMPTY) || out_ready;

  // First requesting lane at or after ptr, wrapping past lane 8.
  always_comb begin
    w_found = 1'b0;
    w_idx   = 4'd0;
    for (int unsigned i = 0; i < LANES; i++) begin
      int unsigned j;
      j = 32'(r_ptr) + i;
      if (j >= LANES) j = j - LANES;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_idx   = 4'(j);
      end
    end
  end

  assign grant = (w_load && w_found && !rst) ? (9'(1) << w_idx) : 9'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_ptr   <= 4'd0;
      r_data  <= '0;
      r_sel   <= 4'd0;
    end else if (w_load) begin
      if (w_found) begin
        r_state <= FULL;
        r_data  <= din[int'(w_idx)*W +: W];
        r_sel   <= w_idx;
        r_ptr   <= (w_idx == 4'd8) ? 4'd0 : w_idx + 4'd1;
      end else begin
        r_state <= EMPTY;
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

`ifdef MUX9_STATS_EN
  logic [15:0] r_xfer_count;

  // Counts consumed words; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_mux9_rr_collector.sv
// Self-checking bench for mux9_rr_collector: directed scenarios plus randomized
// lane traffic, all checked every cycle against a behavioural model.
module tb_mux9_rr_collector;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic [8:0]     req;
  logic [9*W-1:0] din;
  logic [8:0]     grant;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [3:0]     out_sel;

  mux9_rr_collector #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the output register must hold, and the next lane to favour.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  logic [8:0]   g_seen;
  int           n_chk;
  int           n_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [8:0] exp_grant();
    logic [8:0] g;
    g = 9'd0;
    if (!rst && !(m_valid && !out_ready)) begin
      for (int i = 0; i < 9; i++) begin
        int k;
        k = (m_ptr + i) % 9;
        if (g == 9'd0 && req[k]) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [8:0] ge;
    @(negedge clk);
    ge = exp_grant();
    g_seen = grant;
    chk("grant", 32'(grant), 32'(ge));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid || out_ready) begin
      if (ge != 9'd0) begin
        for (int k = 0; k < 9; k++) begin
          if (ge[k]) begin
            m_valid = 1'b1;
            m_data  = din[k*W +: W];
            m_sel   = k;
            m_ptr   = (k + 1) % 9;
          end
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic rand_din();
    for (int k = 0; k < 9; k++) din[k*W +: W] = W'($urandom);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    rst = 1'b1; req = 9'h1FF; out_ready = 1'b1; din = '0;
    rand_din();

    // Reset held two cycles with every lane requesting.
    step(); chk("rst_grant0", 32'(g_seen), 32'h0);
    step(); chk("rst_grant1", 32'(g_seen), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    rst = 1'b0;

    // Fairness: all lanes held, grants walk 0..8 then back to 0.
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) chk("first_grant", 32'(g_seen), 32'h001);
      chk("rr_sel", 32'(out_sel), 32'(i % 9));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Single lane.
    req = 9'h000; step();
    chk("drain_valid", 32'(out_valid), 32'h0);
    req = 9'h010; din[4*W +: W] = 8'hA5; step();
    chk("single_grant", 32'(g_seen), 32'h010);
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_sel", 32'(out_sel), 32'h4);
    chk("single_data", 32'(out_data), 32'hA5);
    req = 9'h000; step();
    chk("single_after", 32'(out_valid), 32'h0);

    // Wrap: grant lane 7 puts ptr at 8, so lane 8 beats lane 0.
    req = 9'h080; step();
    req = 9'h101; step(); chk("wrap_first", 32'(g_seen), 32'h100);
    req = 9'h001; step(); chk("wrap_second", 32'(g_seen), 32'h001);
    req = 9'h000; step();

    // Backpressure with lane 2 held in the output, lane 3 waiting.
    req = 9'h004; din[2*W +: W] = 8'h3C; step();
    req = 9'h008; din[3*W +: W] = 8'hC3; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_grant", 32'(g_seen), 32'h0);
      chk("bp_sel", 32'(out_sel), 32'h2);
      chk("bp_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1; step();
    chk("bp_release_grant", 32'(g_seen), 32'h008);
    chk("bp_release_sel", 32'(out_sel), 32'h3);
    chk("bp_release_valid", 32'(out_valid), 32'h1);

    // Reset mid-operation discards the held word and rewinds ptr.
    req = 9'h020; step();
    chk("mid_sel", 32'(out_sel), 32'h5);
    rst = 1'b1; req = 9'h1FF; step();
    chk("mid_rst_grant", 32'(g_seen), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0; step();
    chk("mid_rst_ptr", 32'(g_seen), 32'h001);

    // Random lane traffic honouring the hold-until-granted protocol.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 9; k++) begin
        if (g_seen[k]) req[k] = 1'b0;
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1;
          din[k*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
